double_buffered_register_bank: RTL and testbench
================================================

DOUBLE_BUFFERED_REGISTER_BANK -- requirements
Module: double_buffered_register_bank

Interface
REQ-001 Parameter WIDTH, default 8: bits per entry, at least 1.
REQ-002 Parameter DEPTH, default 16: entries per bank, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 4: address bits; DEPTH SHALL be at most 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 write_enable  input  1  write strobe into the shadow bank.
REQ-007 write_addr  input  ADDR_WIDTH  shadow-bank entry to write.
REQ-008 write_mask  input  WIDTH  per-bit write enable; 1 = update the bit.
REQ-009 d  input  WIDTH  write data.
REQ-010 read_addr  input  ADDR_WIDTH  active-bank entry to read.
REQ-011 q  output  WIDTH  registered read data.
REQ-012 swap_request  input  1  request to exchange the active and shadow banks.
REQ-013 frame_sync  input  1  one-cycle boundary strobe; swaps take effect only here.
REQ-014 swap_pending  output  1  registered flag: swap requested, not yet taken.
REQ-015 active_bank  output  1  registered index (0/1) of the bank driving q.

Function
REQ-016 Storage: two banks, each DEPTH x WIDTH; the shadow bank SHALL be the bank not equal to active_bank.
REQ-017 Write: when write_enable=1 and write_addr<DEPTH, bit i of shadow[write_addr] SHALL become d[i] where write_mask[i]=1; all other bits SHALL be held.
REQ-018 A write with write_mask all-zero SHALL change nothing.
REQ-019 A write with write_addr>=DEPTH SHALL be ignored, with no aliasing.
REQ-020 The active bank SHALL never be written; therefore no write-to-read bypass exists.
REQ-021 Read: q at edge n+1 SHALL equal active[read_addr], both sampled at edge n (latency 1), and SHALL update every cycle.
REQ-022 A read with read_addr>=DEPTH SHALL return all-zero.
REQ-023 Swap pending: swap_request=1 with frame_sync=0 SHALL set swap_pending=1 at the next edge.
REQ-024 swap_request while swap_pending=1 SHALL have no additional effect; requests do not queue or count.
REQ-025 Swap: when frame_sync=1 and (swap_pending=1 or swap_request=1), active_bank SHALL toggle and swap_pending SHALL clear at the same edge.
REQ-026 frame_sync=1 with no pending or current request SHALL change nothing.
REQ-027 Same-cycle write and swap: the write SHALL land in the pre-swap shadow bank, so the data is visible in the new active bank.
REQ-028 Same-cycle read and swap: q SHALL come from the pre-swap active bank; post-swap data appears for reads issued from the next cycle.
REQ-029 Swap SHALL NOT copy data between banks; the new shadow bank keeps its old active contents.

Reset
REQ-030 reset_n=0 at an edge SHALL force q=0, active_bank=0, swap_pending=0 and every entry of both banks to 0.
REQ-031 Reset SHALL take priority over write, read, swap_request and frame_sync in the same cycle.
REQ-032 A pending swap SHALL be discarded by reset; first post-reset edge with reset_n=1 SHALL behave normally.

Verification
REQ-033 Masked write: WIDTH=8, shadow[3]=0x00; write d=0xFF, mask=0x0F; swap via request+frame_sync -> read addr 3 gives q=0x0F one cycle later.
REQ-034 Deferred swap: swap_request at cycle 0, frame_sync at cycle 5 -> swap_pending=1 over cycles 1-5, active_bank toggles and swap_pending=0 after edge 5; a second request at cycle 2 does not cause a second toggle.
REQ-035 Collision: write addr 2 = 0xA5 and frame_sync+swap_request in the same cycle -> next cycle read addr 2 returns 0xA5; a read issued in the swap cycle returns the old active value.
REQ-036 Bounds: DEPTH=10, ADDR_WIDTH=4; write addr 12 = 0x55 -> no entry changes; read addr 12 -> q=0x00.
REQ-037 Reset mid-operation: swap_pending=1, banks loaded, reset_n=0 for one cycle coinciding with frame_sync -> active_bank=0, swap_pending=0, all reads 0 afterwards.
REQ-038 Idle sync: frame_sync pulses with no request -> active_bank and swap_pending unchanged, q stable for a constant read_addr.

Source files
------------

// File: rtl/double_buffered_register_bank.sv
// Two-bank register file: writes go to the shadow bank, reads come from the active bank.
// Read latency 1 cycle; no backpressure. Bank exchange is requested any time, taken only on frame_sync.
module double_buffered_register_bank #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WIDTH-1:0]      write_mask,
    input  logic [WIDTH-1:0]      d,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      q,
    input  logic                  swap_request,
    input  logic                  frame_sync,
    output logic                  swap_pending,
    output logic                  active_bank
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [WIDTH-1:0] q_q, q_d;
    logic             active_q, active_d;
    logic             pending_q, pending_d;
    logic             shadow_bank;
    logic             swap_take;
    logic             wr_ok;
    logic             rd_ok;

    always_comb begin
        shadow_bank = ~active_q;
        swap_take   = frame_sync & (pending_q | swap_request);
        active_d    = active_q ^ swap_take;
        // A request arriving together with the taken swap is consumed by it.
        pending_d   = swap_take ? 1'b0 : (pending_q | swap_request);
        wr_ok       = write_enable & ({1'b0, write_addr} < DEPTH_W);
        rd_ok       = {1'b0, read_addr} < DEPTH_W;
        q_d         = '0;
        if (rd_ok) begin
            q_d = mem_q[active_q][read_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q       <= '0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            q_q       <= q_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            // Shadow index uses the pre-swap bank, so a write in the swap cycle becomes visible afterwards.
            if (wr_ok) begin
                mem_q[shadow_bank][write_addr] <=
                    (mem_q[shadow_bank][write_addr] & ~write_mask) | (d & write_mask);
            end
        end
    end

    assign q            = q_q;
    assign swap_pending = pending_q;
    assign active_bank  = active_q;

endmodule

// File: tb/tb_double_buffered_register_bank.sv
// Directed bench for double_buffered_register_bank (WIDTH=8, DEPTH=10, ADDR_WIDTH=4).
module tb_double_buffered_register_bank;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       write_enable;
    logic [3:0] write_addr;
    logic [7:0] write_mask;
    logic [7:0] d;
    logic [3:0] read_addr;
    logic [7:0] q;
    logic       swap_request;
    logic       frame_sync;
    logic       swap_pending;
    logic       active_bank;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    double_buffered_register_bank #(
        .WIDTH(8), .DEPTH(10), .ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_mask(write_mask), .d(d), .read_addr(read_addr), .q(q),
        .swap_request(swap_request), .frame_sync(frame_sync),
        .swap_pending(swap_pending), .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] data, input logic [7:0] m);
        write_enable = 1'b1;
        write_addr   = a;
        d            = data;
        write_mask   = m;
    endtask

    initial begin
        reset_n = 1'b0; write_enable = 1'b0; write_addr = '0; write_mask = '0;
        d = '0; read_addr = '0; swap_request = 1'b0; frame_sync = 1'b0;

        // Reset state
        step(); step();
        check("reset_q", q, 0);
        check("reset_active", active_bank, 0);
        check("reset_pending", swap_pending, 0);

        // Shadow writes into bank 1 while bank 0 is active
        reset_n = 1'b1; read_addr = 4'd3;
        wr(4'd3, 8'hFF, 8'h0F); step();
        check("no_bypass_q", q, 8'h00);
        wr(4'd3, 8'h00, 8'h00); step();
        wr(4'd4, 8'h3C, 8'hFF); step();
        wr(4'd4, 8'hC3, 8'hF0); step();
        wr(4'd12, 8'h55, 8'hFF); step();
        write_enable = 1'b0;
        check("active_unchanged_q", q, 8'h00);

        // Swap with immediate frame_sync; read in the swap cycle sees old bank
        swap_request = 1'b1; frame_sync = 1'b1; step();
        swap_request = 1'b0; frame_sync = 1'b0;
        check("swap_active", active_bank, 1);
        check("swap_pending_clr", swap_pending, 0);
        check("swap_cycle_read", q, 8'h00);
        step();
        check("masked_write_addr3", q, 8'h0F);
        read_addr = 4'd4; step();
        check("masked_write_addr4", q, 8'hCC);
        read_addr = 4'd2; step();
        check("no_alias_addr2", q, 8'h00);
        read_addr = 4'd12; step();
        check("oob_read", q, 8'h00);

        // Deferred swap: request at cycle 0, frame_sync at cycle 5
        swap_request = 1'b1; step();
        check("defer_pending_c1", swap_pending, 1);
        swap_request = 1'b0;
        wr(4'd5, 8'h77, 8'hFF); step();
        write_enable = 1'b0;
        check("defer_pending_c2", swap_pending, 1);
        swap_request = 1'b1; step();
        swap_request = 1'b0;
        check("defer_second_req", swap_pending, 1);
        check("defer_active_hold", active_bank, 1);
        step(); step();
        check("defer_pending_c5", swap_pending, 1);
        frame_sync = 1'b1; step();
        frame_sync = 1'b0;
        check("defer_active_toggle", active_bank, 0);
        check("defer_pending_clr", swap_pending, 0);
        read_addr = 4'd5; step();
        check("defer_no_second_toggle", active_bank, 0);
        check("defer_written_data", q, 8'h77);

        // Collision: write and swap in the same cycle
        wr(4'd2, 8'hA5, 8'hFF); swap_request = 1'b1; frame_sync = 1'b1; read_addr = 4'd2;
        step();
        write_enable = 1'b0; swap_request = 1'b0; frame_sync = 1'b0;
        check("collide_old_read", q, 8'h00);
        check("collide_active", active_bank, 1);
        step();
        check("collide_new_read", q, 8'hA5);
        read_addr = 4'd3; step();
        check("no_copy_addr3", q, 8'h0F);

        // Idle frame_sync pulses
        read_addr = 4'd4; frame_sync = 1'b1; step();
        check("idle_active", active_bank, 1);
        check("idle_pending", swap_pending, 0);
        check("idle_q1", q, 8'hCC);
        step();
        frame_sync = 1'b0;
        check("idle_q2", q, 8'hCC);
        check("idle_active2", active_bank, 1);

        // Reset mid-operation coinciding with frame_sync
        swap_request = 1'b1; step();
        swap_request = 1'b0;
        check("pre_reset_pending", swap_pending, 1);
        reset_n = 1'b0; frame_sync = 1'b1; step();
        reset_n = 1'b1; frame_sync = 1'b0;
        check("rst_active", active_bank, 0);
        check("rst_pending", swap_pending, 0);
        check("rst_q", q, 8'h00);
        read_addr = 4'd5; step();
        check("rst_bank0_addr5", q, 8'h00);
        check("rst_pending_after", swap_pending, 0);
        swap_request = 1'b1; frame_sync = 1'b1; read_addr = 4'd3; step();
        swap_request = 1'b0; frame_sync = 1'b0;
        check("post_rst_swap", active_bank, 1);
        step();
        check("rst_bank1_addr3", q, 8'h00);
        read_addr = 4'd2; step();
        check("rst_bank1_addr2", q, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
